// File: rtl/data_memory_lsu_pkg.sv
// Shared constants and types for the data-memory load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int BE_WIDTH = 4;

  typedef enum logic {CLEAR, RUN} lsu_state_t;

  function automatic logic legal_load(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic legal_store(input logic [2:0] f3);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
  endfunction

endpackage

// File: rtl/data_memory_lsu_if.sv
// Access bus between the ALU/datapath side (master) and the load/store unit (slave).
interface data_memory_lsu_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  mem_read;
  logic                  mem_write;
  logic [2:0]            funct3;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  fault;
  logic                  fault_sticky;
  logic                  busy;

  modport master (
    output addr, wdata, mem_read, mem_write, funct3,
    input  rdata, fault, fault_sticky, busy
  );

  modport slave (
    input  addr, wdata, mem_read, mem_write, funct3,
    output rdata, fault, fault_sticky, busy
  );
endinterface

// File: rtl/data_memory_lsu_dmem_array.sv
// Word-organised storage: one byte-enabled synchronous write port, one asynchronous read port.
module dmem_array
  import lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_WIDTH   = $clog2(DEPTH_WORDS)
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [BE_WIDTH-1:0]     be,
  input  logic [IDX_WIDTH-1:0]    widx,
  input  logic [BE_WIDTH*8-1:0]   wdata,
  input  logic [IDX_WIDTH-1:0]    ridx,
  output logic [BE_WIDTH*8-1:0]   rdata
);

  logic [BE_WIDTH*8-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BE_WIDTH; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/data_memory_lsu.sv
// RV32I load/store stage: post-reset zero sweep, lane select/extend, byte-enabled stores, fault flags.
module data_memory_lsu
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_WIDTH   = $clog2(DEPTH_WORDS)
) (
  input  logic             clk,
  input  logic             reset,
  data_memory_lsu_if.slave bus
);

  lsu_state_t            state;
  logic [IDX_WIDTH-1:0]  clr_idx;
  logic                  fault_sticky_q;
  logic                  busy_q;

  logic [IDX_WIDTH-1:0]  word_idx;
  logic [1:0]            lane;
  logic                  running;
  logic                  misaligned;
  logic                  fault_c;
  logic [BE_WIDTH-1:0]   st_be;
  logic [31:0]           st_data;
  logic [31:0]           mem_word;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [31:0]           ld_ext;
  logic                  arr_we;
  logic [IDX_WIDTH-1:0]  arr_widx;
  logic [BE_WIDTH-1:0]   arr_be;
  logic [31:0]           arr_wdata;
  logic                  unused_addr_bits;

  // Address bits above the array are deliberately dropped so accesses wrap.
  assign word_idx         = bus.addr[IDX_WIDTH+1:2];
  assign lane             = bus.addr[1:0];
  assign unused_addr_bits = ^bus.addr[DATA_WIDTH-1:IDX_WIDTH+2];
  assign running          = (state == RUN);

  always_comb begin
    misaligned = 1'b0;
    case (bus.funct3[1:0])
      2'b01:   misaligned = lane[0];
      2'b10:   misaligned = (lane != 2'b00);
      default: misaligned = 1'b0;
    endcase
    fault_c = running && (bus.mem_read || bus.mem_write) &&
              (misaligned ||
               (bus.mem_read && bus.mem_write) ||
               (bus.mem_read && !legal_load(bus.funct3)) ||
               (bus.mem_write && !legal_store(bus.funct3)));
  end

  always_comb begin
    st_be   = 4'b1111;
    st_data = bus.wdata;
    case (bus.funct3)
      F3_B: begin
        st_be   = 4'b0001 << lane;
        st_data = {4{bus.wdata[7:0]}};
      end
      F3_H: begin
        st_be   = lane[1] ? 4'b1100 : 4'b0011;
        st_data = {2{bus.wdata[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = bus.wdata;
      end
    endcase
  end

  assign ld_byte = mem_word[{lane, 3'b000} +: 8];
  assign ld_half = lane[1] ? mem_word[31:16] : mem_word[15:0];

  always_comb begin
    ld_ext = '0;
    case (bus.funct3)
      F3_B:    ld_ext = {{24{ld_byte[7]}}, ld_byte};
      F3_H:    ld_ext = {{16{ld_half[15]}}, ld_half};
      F3_W:    ld_ext = mem_word;
      F3_BU:   ld_ext = {24'h0, ld_byte};
      F3_HU:   ld_ext = {16'h0, ld_half};
      default: ld_ext = '0;
    endcase
  end

  // The sweep owns the single write port until it finishes; reset blocks every write.
  assign arr_we    = !reset && (!running || (bus.mem_write && !fault_c));
  assign arr_widx  = running ? word_idx : clr_idx;
  assign arr_be    = running ? st_be : 4'b1111;
  assign arr_wdata = running ? st_data : 32'h0;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_WIDTH   (IDX_WIDTH)
  ) u_array (
    .clk   (clk),
    .we    (arr_we),
    .be    (arr_be),
    .widx  (arr_widx),
    .wdata (arr_wdata),
    .ridx  (word_idx),
    .rdata (mem_word)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= CLEAR;
      clr_idx        <= '0;
      fault_sticky_q <= 1'b0;
      busy_q         <= 1'b1;
    end else if (state == CLEAR) begin
      clr_idx <= clr_idx + 1'b1;
      if (clr_idx == IDX_WIDTH'(DEPTH_WORDS - 1)) begin
        state  <= RUN;
        busy_q <= 1'b0;
      end
    end else if (fault_c) begin
      fault_sticky_q <= 1'b1;
    end
  end

  assign bus.rdata        = (running && bus.mem_read && !fault_c) ? ld_ext : '0;
  assign bus.fault        = fault_c;
  assign bus.fault_sticky = fault_sticky_q;
  assign bus.busy         = busy_q;

endmodule
